// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS memory-access (M) stage:
//   - load/store opcode constants (instruction bits [31:26])
//   - M-stage FSM state encoding
//   - NOP instruction used as the bubble presented to WB while stalled
//   - mem_decode(): classifies an opcode/address pair as load, store and/or
//     misaligned; used both on the held M instruction and on the instruction
//     about to be loaded so both views always agree.
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [31:0] NOP_INS = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic is_load;
    logic is_store;
    logic misaligned;
  } mem_kind_t;

  // Word ops need addr[1:0]==0, halfword ops need addr[0]==0, byte ops never fault.
  function automatic mem_kind_t mem_decode(input logic [5:0] op, input logic [1:0] addr);
    mem_kind_t k;
    k.is_load    = 1'b0;
    k.is_store   = 1'b0;
    k.misaligned = 1'b0;
    case (op)
      OP_LW: begin
        k.is_load    = 1'b1;
        k.misaligned = (addr != 2'b00);
      end
      OP_LH, OP_LHU: begin
        k.is_load    = 1'b1;
        k.misaligned = addr[0];
      end
      OP_LB, OP_LBU: begin
        k.is_load    = 1'b1;
      end
      OP_SW: begin
        k.is_store   = 1'b1;
        k.misaligned = (addr != 2'b00);
      end
      OP_SH: begin
        k.is_store   = 1'b1;
        k.misaligned = addr[0];
      end
      OP_SB: begin
        k.is_store   = 1'b1;
      end
      default: begin
        k.is_load    = 1'b0;
        k.is_store   = 1'b0;
        k.misaligned = 1'b0;
      end
    endcase
    return k;
  endfunction

endpackage

// File: rtl/mem_store_align.sv
// -----------------------------------------------------------------------------
// mem_store_align
// Combinational decode of a load/store for the data-memory interface.
// Ports:
//   opcode_i     [5:0]  instruction bits [31:26]
//   addr_i       [1:0]  low effective-address bits
//   st_data_i    [31:0] store data (rt value)
//   is_load_o           opcode is a load
//   is_store_o          opcode is a store
//   misaligned_o        access violates its natural alignment
//   dm_be_o      [3:0]  byte enables (all ones for loads, 0 for non-memory)
//   dm_wdata_o   [31:0] store data replicated across the byte lanes
// -----------------------------------------------------------------------------
module mem_store_align
  import mips_pkg::*;
(
  input  logic [5:0]  opcode_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] st_data_i,
  output logic        is_load_o,
  output logic        is_store_o,
  output logic        misaligned_o,
  output logic [3:0]  dm_be_o,
  output logic [31:0] dm_wdata_o
);

  mem_kind_t kind_s;

  assign kind_s       = mem_decode(opcode_i, addr_i);
  assign is_load_o    = kind_s.is_load;
  assign is_store_o   = kind_s.is_store;
  assign misaligned_o = kind_s.misaligned;

  // Byte enables and lane replication; memory picks the lanes via dm_be.
  always_comb begin
    dm_be_o    = 4'b0000;
    dm_wdata_o = 32'h0000_0000;
    case (opcode_i)
      OP_SW: begin
        dm_be_o    = 4'b1111;
        dm_wdata_o = st_data_i;
      end
      OP_SH: begin
        dm_be_o    = addr_i[1] ? 4'b1100 : 4'b0011;
        dm_wdata_o = {2{st_data_i[15:0]}};
      end
      OP_SB: begin
        dm_be_o    = 4'b0001 << addr_i;
        dm_wdata_o = {4{st_data_i[7:0]}};
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        dm_be_o    = 4'b1111;
        dm_wdata_o = 32'h0000_0000;
      end
      default: begin
        dm_be_o    = 4'b0000;
        dm_wdata_o = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/line_mem.sv
// -----------------------------------------------------------------------------
// line_mem
// Memory-access (M) stage of the 5-stage MIPS pipeline. Holds the EX->M
// register, issues one req/ack data-memory access per load/store, stalls the
// front of the pipeline while it is outstanding and hands ins/pc/alu_result
// plus the raw memory word to WB.
// Ports:
//   clk, reset (async, active low)
//   ins_in, pc_in, alu_result_in, st_data_in        from EX
//   dm_req, dm_we, dm_addr, dm_be, dm_wdata          request to data memory
//   dm_ack, dm_rdata                                 completion from memory
//   stall_out                                        freeze PC/IF/ID/EX
//   ins_out, pc_out, alu_result_out, dm_data_out     to WB
//   exc_align                                        M instruction misaligned
//   exc_bus                                          access timed out (pulse)
// -----------------------------------------------------------------------------
module line_mem
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ins_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] st_data_in,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        stall_out,
  output logic [31:0] ins_out,
  output logic [31:0] pc_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] dm_data_out,
  output logic        exc_align,
  output logic        exc_bus
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  state_e            state_q, state_d;
  logic [31:0]       ins_q, ins_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       alu_q, alu_d;
  logic [31:0]       st_data_q, st_data_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              exc_bus_q, exc_bus_d;

  logic              m_is_load_s;
  logic              m_is_store_s;
  logic              m_misaligned_s;
  logic [3:0]        m_be_s;
  logic [31:0]       m_wdata_s;
  mem_kind_t         nx_kind_s;
  logic              nx_mem_s;
  logic              stall_s;

  mem_store_align u_align (
    .opcode_i     (ins_q[31:26]),
    .addr_i       (alu_q[1:0]),
    .st_data_i    (st_data_q),
    .is_load_o    (m_is_load_s),
    .is_store_o   (m_is_store_s),
    .misaligned_o (m_misaligned_s),
    .dm_be_o      (m_be_s),
    .dm_wdata_o   (m_wdata_s)
  );

  // Classify the instruction that will be loaded at the next unstalled edge.
  assign nx_kind_s = mem_decode(ins_in[31:26], alu_result_in[1:0]);
  assign nx_mem_s  = (nx_kind_s.is_load | nx_kind_s.is_store) & ~nx_kind_s.misaligned;
  assign stall_s   = (state_q == ST_REQ);

  // M register next state: load from EX unless an access is outstanding.
  always_comb begin
    ins_d     = ins_q;
    pc_d      = pc_q;
    alu_d     = alu_q;
    st_data_d = st_data_q;
    if (stall_s) begin
      ins_d     = ins_q;
      pc_d      = pc_q;
      alu_d     = alu_q;
      st_data_d = st_data_q;
    end else begin
      ins_d     = ins_in;
      pc_d      = pc_in;
      alu_d     = alu_result_in;
      st_data_d = st_data_in;
    end
  end

  // M register storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ins_q     <= 32'h0000_0000;
      pc_q      <= 32'h0000_0000;
      alu_q     <= 32'h0000_0000;
      st_data_q <= 32'h0000_0000;
    end else begin
      ins_q     <= ins_d;
      pc_q      <= pc_d;
      alu_q     <= alu_d;
      st_data_q <= st_data_d;
    end
  end

  // FSM next state, wait counter, read-data capture and timeout flag.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    exc_bus_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        cnt_d   = CNT_ZERO;
        state_d = nx_mem_s ? ST_REQ : ST_IDLE;
      end
      ST_REQ: begin
        // An ack on the timeout edge still completes normally.
        if (dm_ack) begin
          rdata_d = m_is_load_s ? dm_rdata : 32'h0000_0000;
          cnt_d   = CNT_ZERO;
          state_d = ST_DONE;
        end else if (cnt_q == TIMEOUT_C) begin
          rdata_d   = 32'h0000_0000;
          exc_bus_d = 1'b1;
          cnt_d     = CNT_ZERO;
          state_d   = ST_DONE;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = ST_REQ;
        end
      end
      default: begin
        cnt_d   = CNT_ZERO;
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state, counter and captured data storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= CNT_ZERO;
      rdata_q   <= 32'h0000_0000;
      exc_bus_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      exc_bus_q <= exc_bus_d;
    end
  end

  // Output decode from registered state; request fields held from M during REQ.
  always_comb begin
    dm_req         = 1'b0;
    dm_we          = 1'b0;
    dm_addr        = 32'h0000_0000;
    dm_be          = 4'b0000;
    dm_wdata       = 32'h0000_0000;
    stall_out      = 1'b0;
    ins_out        = NOP_INS;
    pc_out         = 32'h0000_0000;
    alu_result_out = 32'h0000_0000;
    dm_data_out    = 32'h0000_0000;
    case (state_q)
      ST_IDLE: begin
        ins_out        = ins_q;
        pc_out         = pc_q;
        alu_result_out = alu_q;
      end
      ST_REQ: begin
        dm_req    = 1'b1;
        dm_we     = m_is_store_s;
        dm_addr   = {alu_q[31:2], 2'b00};
        dm_be     = m_be_s;
        dm_wdata  = m_wdata_s;
        stall_out = 1'b1;
      end
      ST_DONE: begin
        ins_out        = ins_q;
        pc_out         = pc_q;
        alu_result_out = alu_q;
        dm_data_out    = rdata_q;
      end
      default: begin
        ins_out = NOP_INS;
      end
    endcase
  end

  assign exc_align = m_misaligned_s;
  assign exc_bus   = exc_bus_q;

endmodule

// File: tb/tb_line_mem.sv
// -----------------------------------------------------------------------------
// tb_line_mem
// Directed bench for the M stage: inputs change 1 time unit after each rising
// edge, outputs are checked at that same point (they depend only on state
// loaded at the edge).
// -----------------------------------------------------------------------------
module tb_line_mem;

  localparam logic [31:0] ADDU   = 32'h0022_1821;
  localparam logic [31:0] LW1    = 32'h8C43_0004;
  localparam logic [31:0] SB1    = 32'hA043_0003;
  localparam logic [31:0] SH_OK  = 32'hA443_0002;
  localparam logic [31:0] SH_BAD = 32'hA443_0001;
  localparam logic [31:0] LW_TO  = 32'h8C44_0000;
  localparam logic [31:0] LW_LT  = 32'h8C44_0004;
  localparam logic [31:0] LW4    = 32'h8C45_0000;
  localparam logic [31:0] SW4    = 32'hAC45_0008;

  logic        clk;
  logic        reset;
  logic [31:0] ins_in, pc_in, alu_result_in, st_data_in;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        stall_out;
  logic [31:0] ins_out, pc_out, alu_result_out, dm_data_out;
  logic        exc_align, exc_bus;

  int vectors;
  int miscompares;

  line_mem #(.TIMEOUT(15), .CNT_W(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .ins_in         (ins_in),
    .pc_in          (pc_in),
    .alu_result_in  (alu_result_in),
    .st_data_in     (st_data_in),
    .dm_req         (dm_req),
    .dm_we          (dm_we),
    .dm_addr        (dm_addr),
    .dm_be          (dm_be),
    .dm_wdata       (dm_wdata),
    .dm_ack         (dm_ack),
    .dm_rdata       (dm_rdata),
    .stall_out      (stall_out),
    .ins_out        (ins_out),
    .pc_out         (pc_out),
    .alu_result_out (alu_result_out),
    .dm_data_out    (dm_data_out),
    .exc_align      (exc_align),
    .exc_bus        (exc_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] alu, input logic [31:0] sd);
    ins_in        = ins;
    pc_in         = pc;
    alu_result_in = alu;
    st_data_in    = sd;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    dm_ack      = 1'b1;
    dm_rdata    = 32'h5555_AAAA;
    feed(ADDU, 32'h0000_0100, 32'h0000_0042, 32'h0000_0077);

    // Reset held with ack high: everything zero.
    tick();
    tick();
    chk("rst_req",   {31'd0, dm_req},    32'd0);
    chk("rst_stall", {31'd0, stall_out}, 32'd0);
    chk("rst_ins",   ins_out,            32'd0);
    chk("rst_pc",    pc_out,             32'd0);
    chk("rst_alu",   alu_result_out,     32'd0);
    chk("rst_data",  dm_data_out,        32'd0);
    chk("rst_exc",   {30'd0, exc_align, exc_bus}, 32'd0);
    chk("rst_addr",  dm_addr,            32'd0);

    // Release, addu passes through in one cycle.
    reset  = 1'b1;
    dm_ack = 1'b0;
    tick();
    chk("addu_ins",   ins_out,            ADDU);
    chk("addu_pc",    pc_out,             32'h0000_0100);
    chk("addu_alu",   alu_result_out,     32'h0000_0042);
    chk("addu_req",   {31'd0, dm_req},    32'd0);
    chk("addu_stall", {31'd0, stall_out}, 32'd0);

    // lw 0x1004, ack in third REQ cycle.
    feed(LW1, 32'h0000_0104, 32'h0000_1004, 32'h0000_0000);
    tick();
    chk("lw_req1",   {31'd0, dm_req},    32'd1);
    chk("lw_we",     {31'd0, dm_we},     32'd0);
    chk("lw_addr",   dm_addr,            32'h0000_1004);
    chk("lw_be",     {28'd0, dm_be},     32'h0000_000F);
    chk("lw_stall1", {31'd0, stall_out}, 32'd1);
    chk("lw_bubble", ins_out,            32'd0);
    feed(ADDU, 32'h0000_0108, 32'h0000_9999, 32'h0000_0000);
    tick();
    chk("lw_req2",   {31'd0, dm_req},    32'd1);
    chk("lw_addr2",  dm_addr,            32'h0000_1004);
    tick();
    chk("lw_req3",   {31'd0, dm_req},    32'd1);
    chk("lw_stall3", {31'd0, stall_out}, 32'd1);
    dm_ack   = 1'b1;
    dm_rdata = 32'hDEAD_BEEF;
    tick();
    chk("lw_data",   dm_data_out,        32'hDEAD_BEEF);
    chk("lw_ins",    ins_out,            LW1);
    chk("lw_pc",     pc_out,             32'h0000_0104);
    chk("lw_done_req",   {31'd0, dm_req},    32'd0);
    chk("lw_done_stall", {31'd0, stall_out}, 32'd0);

    // ADDU loads; ack pulses in IDLE must be ignored.
    dm_ack = 1'b0;
    feed(ADDU, 32'h0000_0108, 32'h0000_0010, 32'h0000_0000);
    tick();
    chk("idle_data", dm_data_out, 32'd0);
    dm_ack   = 1'b1;
    dm_rdata = 32'h1234_5678;
    tick();
    chk("idle_ack_req",  {31'd0, dm_req}, 32'd0);
    chk("idle_ack_data", dm_data_out,     32'd0);

    // sb 0x2003, immediate ack.
    dm_ack = 1'b0;
    feed(SB1, 32'h0000_0110, 32'h0000_2003, 32'h0000_00A5);
    tick();
    chk("sb_we",    {31'd0, dm_we},     32'd1);
    chk("sb_be",    {28'd0, dm_be},     32'h0000_0008);
    chk("sb_wdata", dm_wdata,           32'hA5A5_A5A5);
    chk("sb_addr",  dm_addr,            32'h0000_2000);
    chk("sb_stall", {31'd0, stall_out}, 32'd1);
    dm_ack   = 1'b1;
    dm_rdata = 32'hFFFF_FFFF;
    tick();
    chk("sb_done_stall", {31'd0, stall_out}, 32'd0);
    chk("sb_done_data",  dm_data_out,        32'd0);
    chk("sb_done_ins",   ins_out,            SB1);

    // sh 0x2002: upper halfword lanes.
    dm_ack = 1'b0;
    feed(SH_OK, 32'h0000_0114, 32'h0000_2002, 32'h0000_1234);
    tick();
    chk("sh_be",    {28'd0, dm_be}, 32'h0000_000C);
    chk("sh_wdata", dm_wdata,       32'h1234_1234);
    dm_ack = 1'b1;
    tick();
    chk("sh_done_req", {31'd0, dm_req}, 32'd0);

    // sh 0x2001: misaligned, no request, no stall.
    dm_ack = 1'b0;
    feed(SH_BAD, 32'h0000_0118, 32'h0000_2001, 32'h0000_1234);
    tick();
    chk("mis_exc",   {31'd0, exc_align}, 32'd1);
    chk("mis_req",   {31'd0, dm_req},    32'd0);
    chk("mis_stall", {31'd0, stall_out}, 32'd0);
    chk("mis_data",  dm_data_out,        32'd0);
    chk("mis_ins",   ins_out,            SH_BAD);

    // lw without ack: 16 stall cycles then exc_bus in DONE.
    feed(LW_TO, 32'h0000_011C, 32'h0000_3000, 32'h0000_0000);
    tick();
    chk("to_stall1", {31'd0, stall_out}, 32'd1);
    chk("to_align",  {31'd0, exc_align}, 32'd0);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("to_stall_n", {30'd0, stall_out, exc_bus}, 32'd2);
    end
    feed(LW_LT, 32'h0000_0120, 32'h0000_3004, 32'h0000_0000);
    tick();
    chk("to_exc_bus", {31'd0, exc_bus},   32'd1);
    chk("to_data",    dm_data_out,        32'd0);
    chk("to_stall",   {31'd0, stall_out}, 32'd0);
    chk("to_ins",     ins_out,            LW_TO);

    // lw acked exactly at the timeout edge: data taken, no exc_bus.
    tick();
    chk("lt_req1",     {31'd0, dm_req},  32'd1);
    chk("lt_bus_once", {31'd0, exc_bus}, 32'd0);
    for (int i = 0; i < 15; i++) begin
      tick();
    end
    chk("lt_req16", {31'd0, dm_req}, 32'd1);
    dm_ack   = 1'b1;
    dm_rdata = 32'hCAFE_F00D;
    feed(LW4, 32'h0000_0124, 32'h0000_4000, 32'h0000_0000);
    tick();
    chk("lt_data", dm_data_out,      32'hCAFE_F00D);
    chk("lt_bus",  {31'd0, exc_bus}, 32'd0);

    // Back-to-back lw, sw: DONE -> REQ with no idle cycle.
    dm_ack = 1'b0;
    tick();
    chk("b2b_lw_req",  {31'd0, dm_req}, 32'd1);
    chk("b2b_lw_addr", dm_addr,         32'h0000_4000);
    dm_ack   = 1'b1;
    dm_rdata = 32'h1122_3344;
    feed(SW4, 32'h0000_0128, 32'h0000_4008, 32'h89AB_CDEF);
    tick();
    chk("b2b_lw_data", dm_data_out,     32'h1122_3344);
    chk("b2b_lw_ins",  ins_out,         LW4);
    chk("b2b_lw_done", {31'd0, dm_req}, 32'd0);
    dm_ack = 1'b0;
    tick();
    chk("b2b_sw_req",   {30'd0, dm_req, dm_we}, 32'd3);
    chk("b2b_sw_be",    {28'd0, dm_be},         32'h0000_000F);
    chk("b2b_sw_wdata", dm_wdata,               32'h89AB_CDEF);
    chk("b2b_sw_addr",  dm_addr,                32'h0000_4008);

    // Reset mid-REQ: request drops without a clock edge.
    #2;
    dm_ack = 1'b1;
    reset  = 1'b0;
    #1;
    chk("arst_req",   {31'd0, dm_req},    32'd0);
    chk("arst_stall", {31'd0, stall_out}, 32'd0);
    feed(32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
    tick();
    reset = 1'b1;
    tick();
    chk("post_req",  {31'd0, dm_req}, 32'd0);
    chk("post_data", dm_data_out,     32'd0);
    chk("post_ins",  ins_out,         32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/line_mem.md
Name: line_mem

Overview:
- Memory-access stage (M) of the 5-stage MIPS pipeline, directly upstream of the writeback stage.
- Holds the EX->M pipeline register and issues load/store requests to the data memory over a req/ack handshake.
- Stalls the front of the pipeline while an access is outstanding.
- Presents ins, pc, alu_result and raw 32-bit memory word to the WB stage; WB does byte/halfword extraction.

Parameters:
- TIMEOUT, 15, max cycles in REQ without dm_ack before the access is abandoned.
- CNT_W, 4, width of wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- ins_in  in  32  instruction from EX.
- pc_in  in  32  PC from EX.
- alu_result_in  in  32  effective address / ALU result from EX.
- st_data_in  in  32  rt value (forwarded) for stores.
- dm_req  out  1  memory request valid.
- dm_we  out  1  write enable, qualified by dm_req.
- dm_addr  out  32  word address {alu_result[31:2],2'b00}.
- dm_be  out  4  byte enables.
- dm_wdata  out  32  lane-replicated store data.
- dm_ack  in  1  memory completion, one-cycle pulse.
- dm_rdata  in  32  read word, valid with dm_ack.
- stall_out  out  1  freeze PC/IF/ID/EX registers.
- ins_out  out  32  to WB ins_in.
- pc_out  out  32  to WB pc_in.
- alu_result_out  out  32  to WB alu_result_in.
- dm_data_out  out  32  to WB dm_data_in.
- exc_align  out  1  misaligned access flag for current M instruction.
- exc_bus  out  1  timeout flag, one-cycle pulse.

Behaviour:
- Reset (reset=0, async): M register cleared (ins=0, pc=0, alu=0, st_data=0), rdata_q=0, counter=0, state IDLE. All outputs 0.
- M register loads ins_in/pc_in/alu_result_in/st_data_in on every rising edge with stall_out=0. It holds while stall_out=1.
- Decode on ins[31:26]:
  - Loads: lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25.
  - Stores: sb 0x28, sh 0x29, sw 0x2B.
  - All other opcodes are non-memory.
- Alignment:
  - lw/sw require addr[1:0]=0.
  - lh/lhu/sh require addr[0]=0.
  - Misaligned: exc_align=1 while held, no dm_req, treated as non-memory with dm_data_out=0.
- Byte enables:
  - sw 1111.
  - sh: 1100 if addr[1], else 0011.
  - sb: 0001<<addr[1:0].
  - Loads: 1111.
- dm_wdata: sw = data; sh = {2{data[15:0]}}; sb = {4{data[7:0]}}.
- FSM states:
  - IDLE: M holds non-memory or misaligned instr, or is empty.
    - stall_out=0.
    - Outputs pass M register through, dm_data_out=0.
    - Next state is REQ if the next loaded instruction is an aligned memory op.
  - REQ:
    - dm_req=1, dm_we=store.
    - stall_out=1. ins_out=0 (bubble to WB), pc_out/alu_result_out/dm_data_out=0.
    - Counter increments each cycle.
    - On dm_ack: rdata_q<=dm_rdata (loads only; stores leave rdata_q=0), counter<=0, go DONE.
    - If counter==TIMEOUT with no ack: exc_bus pulses, rdata_q<=0, go DONE.
    - dm_ack on the same edge as the timeout wins (data taken, no exc_bus).
  - DONE:
    - dm_req=0, stall_out=0.
    - ins_out/pc_out/alu_result_out from M register, dm_data_out=rdata_q.
    - Next instruction loads at the edge; next state is REQ if that instruction is an aligned memory op, else IDLE.
- Latency:
  - Non-memory instruction: 1 cycle in M.
  - Memory instruction: 1 + (ack wait) + 1 cycles. Minimum 2: ack in the first REQ cycle.
- dm_ack outside REQ is ignored.
- Address/data outputs are held stable throughout REQ.
- Reset asserted mid-REQ: dm_req drops immediately (async); no ack is consumed after release.
- Back-to-back memory ops: DONE -> REQ with no IDLE cycle.

Decomposition:
- Shared package mips_pkg:
  - Opcode constants OP_LB..OP_SW.
  - FSM state encoding ST_IDLE/ST_REQ/ST_DONE (2 bits).
  - NOP instruction constant 32'h0.
- Sub-module mem_store_align (combinational), used by the top-level:
  - Inputs: opcode, addr[1:0], store data.
  - Outputs: is_load, is_store, misaligned, dm_be, dm_wdata.
- Top-level holds the M register, FSM and counter.

Test Plan:
- Reset: hold reset=0 with dm_ack=1 -> all outputs 0, stall_out=0; release, feed addu -> ins_out equals it one edge later, no dm_req.
- lw addr 0x0000_1004, ack after 3 cycles with rdata 0xDEADBEEF:
  - dm_req high 3 cycles, dm_addr=0x1004, dm_be=1111, stall_out high 3 cycles.
  - Next cycle dm_data_out=0xDEADBEEF with ins_out=lw.
- sb addr 0x2003, rt=0x0000_00A5, ack immediate -> dm_we=1, dm_be=1000, dm_wdata=0xA5A5A5A5, stall 1 cycle.
- sh addr 0x2001 -> exc_align=1, dm_req never asserts, no stall, dm_data_out=0.
- lw with no ack, TIMEOUT=15 -> stall 16 cycles, exc_bus pulses once, then DONE with dm_data_out=0; ack at the timeout edge gives data and no exc_bus.
- lw, sw back-to-back, each acked immediately:
  - REQ, DONE, REQ, DONE with no IDLE between.
  - Reset pulsed during the second REQ -> dm_req falls asynchronously, state IDLE.
